// File: rtl/board_pkg.sv
// ---------------------------------------------------------------------------
// board_pkg
// Shared types and constants for the 3x3 game board.
//   cell_t          : one 2-bit cell code (EMPTY / P1 / P2, 2'b11 unused)
//   NUM_CELLS       : number of board cells (positions 0..8)
//   writer_state_t  : state encoding of board_cell_writer
//   other_mark()    : returns the opponent's mark
// ---------------------------------------------------------------------------
package board_pkg;

    localparam int unsigned CELL_W    = 2;
    localparam int unsigned NUM_CELLS = 9;

    typedef logic [CELL_W-1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_P1    = 2'b01;
    localparam cell_t CELL_P2    = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        COMMIT,
        GAME_OVER
    } writer_state_t;

    function automatic cell_t other_mark(input cell_t m);
        return (m == CELL_P1) ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/board_line_check.sv
// ---------------------------------------------------------------------------
// board_line_check
// Combinational detector: reports whether `mark` owns any complete line
// (3 rows, 3 columns, 2 diagonals) of the supplied board.
//   cells [9] : board cells, index 0 = a (top-left) .. 8 = i (bottom-right)
//   mark      : player code to test for
//   line      : 1 when at least one line is fully owned by `mark`
// ---------------------------------------------------------------------------
module board_line_check
    import board_pkg::*;
(
    input  cell_t cells [NUM_CELLS],
    input  cell_t mark,
    output logic  line
);

    function automatic logic owns3(input cell_t x, input cell_t y, input cell_t z,
                                   input cell_t m);
        return (x == m) && (y == m) && (z == m);
    endfunction

    always_comb begin
        line = 1'b0;
        // rows
        line = line | owns3(cells[0], cells[1], cells[2], mark);
        line = line | owns3(cells[3], cells[4], cells[5], mark);
        line = line | owns3(cells[6], cells[7], cells[8], mark);
        // columns
        line = line | owns3(cells[0], cells[3], cells[6], mark);
        line = line | owns3(cells[1], cells[4], cells[7], mark);
        line = line | owns3(cells[2], cells[5], cells[8], mark);
        // diagonals
        line = line | owns3(cells[0], cells[4], cells[8], mark);
        line = line | owns3(cells[2], cells[4], cells[6], mark);
    end

endmodule

// File: rtl/board_cell_writer.sv
// ---------------------------------------------------------------------------
// board_cell_writer
// Owns the 3x3 board register file and serialises move requests into it.
// A request is accepted in IDLE, checked in CHECK and written in COMMIT;
// ack or err appears two cycles after the accept edge.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   move_valid / move_pos  : move request and position (0=a .. 8=i)
//   move_ready             : request can be accepted this cycle
//   move_ack / move_err    : one-cycle result pulses
//   clear                  : synchronous new-game, priority over everything
//   a..i                   : registered cell contents
//   turn                   : mark written by the next accepted move
//   move_cnt               : accepted moves since clear (0..9)
//   game_over              : high while in GAME_OVER
//   winner                 : mover code of a completed line (only with macro)
//
// Optional feature macro: BOARD_WIN_DETECT_EN (line detection + winner port).
// ---------------------------------------------------------------------------
module board_cell_writer
    import board_pkg::*;
#(
    parameter int unsigned CELL_W    = 2,
    parameter int unsigned NUM_CELLS = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              move_valid,
    input  logic [3:0]        move_pos,
    output logic              move_ready,
    output logic              move_ack,
    output logic              move_err,
    input  logic              clear,
    output logic [CELL_W-1:0] a,
    output logic [CELL_W-1:0] b,
    output logic [CELL_W-1:0] c,
    output logic [CELL_W-1:0] d,
    output logic [CELL_W-1:0] e,
    output logic [CELL_W-1:0] f,
    output logic [CELL_W-1:0] g,
    output logic [CELL_W-1:0] h,
    output logic [CELL_W-1:0] i,
    output logic [CELL_W-1:0] turn,
    output logic [3:0]        move_cnt,
    output logic              game_over
`ifdef BOARD_WIN_DETECT_EN
    ,
    output logic [CELL_W-1:0] winner
`endif
);

    writer_state_t state_q, state_d;

    cell_t      cells_q [NUM_CELLS];
    cell_t      turn_q;
    logic [3:0] cnt_q;
    logic [3:0] pos_q;
    logic       err_pend_q;
    logic       bad_move;
    logic       win;
    logic       accept;

    // ---------------------------------------------------------------------
    // Move legality: out of range, or target cell already occupied.
    // Loop compare avoids indexing the array with an out-of-range pos_q.
    // ---------------------------------------------------------------------
    always_comb begin
        bad_move = (pos_q >= 4'(NUM_CELLS));
        for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            if ((pos_q == 4'(k)) && (cells_q[k] != CELL_EMPTY)) begin
                bad_move = 1'b1;
            end
        end
    end

`ifdef BOARD_WIN_DETECT_EN
    cell_t board_upd [NUM_CELLS];

    // Board as it will look after the COMMIT write, so the mover's own
    // move counts toward the line it completes.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            board_upd[k] = (pos_q == 4'(k)) ? turn_q : cells_q[k];
        end
    end

    board_line_check u_line_check (
        .cells (board_upd),
        .mark  (turn_q),
        .line  (win)
    );
`else
    assign win = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      if (accept) state_d = CHECK;
                CHECK:     state_d = bad_move ? IDLE : COMMIT;
                COMMIT:    state_d = ((cnt_q == 4'd8) || win) ? GAME_OVER : IDLE;
                GAME_OVER: state_d = GAME_OVER;
                default:   state_d = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // Ready is held low in the IDLE cycle where a rejected move's err is
    // still pending, so err lands at the same latency as ack and the next
    // accept cannot happen before the result is reported.
    // ---------------------------------------------------------------------
    always_comb begin
        move_ready = (state_q == IDLE) && !err_pend_q;
        game_over  = (state_q == GAME_OVER);
        accept     = move_ready && move_valid;
    end

    // ---------------------------------------------------------------------
    // Datapath: board, turn, counter, request capture, result pulses
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CELLS; k++) cells_q[k] <= CELL_EMPTY;
            turn_q     <= CELL_P1;
            cnt_q      <= '0;
            pos_q      <= '0;
            err_pend_q <= 1'b0;
            move_ack   <= 1'b0;
            move_err   <= 1'b0;
`ifdef BOARD_WIN_DETECT_EN
            winner     <= CELL_EMPTY;
`endif
        end else begin
            move_ack <= 1'b0;
            move_err <= 1'b0;
            if (clear) begin
                for (int unsigned k = 0; k < NUM_CELLS; k++) cells_q[k] <= CELL_EMPTY;
                turn_q     <= CELL_P1;
                cnt_q      <= '0;
                err_pend_q <= 1'b0;
`ifdef BOARD_WIN_DETECT_EN
                winner     <= CELL_EMPTY;
`endif
            end else begin
                move_err   <= err_pend_q;
                err_pend_q <= 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (accept) pos_q <= move_pos;
                    end
                    CHECK: begin
                        if (bad_move) err_pend_q <= 1'b1;
                    end
                    COMMIT: begin
                        for (int unsigned k = 0; k < NUM_CELLS; k++) begin
                            if (pos_q == 4'(k)) cells_q[k] <= turn_q;
                        end
                        turn_q   <= other_mark(turn_q);
                        cnt_q    <= (cnt_q >= 4'd9) ? 4'd9 : cnt_q + 4'd1;
                        move_ack <= 1'b1;
`ifdef BOARD_WIN_DETECT_EN
                        if (win) winner <= turn_q;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign a        = cells_q[0];
    assign b        = cells_q[1];
    assign c        = cells_q[2];
    assign d        = cells_q[3];
    assign e        = cells_q[4];
    assign f        = cells_q[5];
    assign g        = cells_q[6];
    assign h        = cells_q[7];
    assign i        = cells_q[8];
    assign turn     = turn_q;
    assign move_cnt = cnt_q;

endmodule

// File: tb/tb_board_cell_writer.sv
// ---------------------------------------------------------------------------
// tb_board_cell_writer
// Directed self-checking bench for board_cell_writer. Build with
// BOARD_WIN_DETECT_EN defined to exercise the winner path instead of the
// nine-move draw.
// ---------------------------------------------------------------------------
module tb_board_cell_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       move_ack;
    logic       move_err;
    logic       clear;
    logic [1:0] a, b, c, d, e, f, g, h, i;
    logic [1:0] turn;
    logic [3:0] move_cnt;
    logic       game_over;
`ifdef BOARD_WIN_DETECT_EN
    logic [1:0] winner;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    board_cell_writer #(
        .CELL_W    (2),
        .NUM_CELLS (9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .move_ready (move_ready),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .clear      (clear),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .g          (g),
        .h          (h),
        .i          (i),
        .turn       (turn),
        .move_cnt   (move_cnt),
        .game_over  (game_over)
`ifdef BOARD_WIN_DETECT_EN
        ,
        .winner     (winner)
`endif
    );

    function automatic logic [17:0] board_word();
        return {a, b, c, d, e, f, g, h, i};
    endfunction

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Request at edge N, garble move_pos afterwards, then look at N+1 and N+2.
    task automatic do_move(input logic [3:0] pos, input logic exp_ack, input logic exp_err);
        @(negedge clk);
        check("ready_before_move", move_ready, 1);
        move_valid = 1'b1;
        move_pos   = pos;
        @(posedge clk); #1;
        move_valid = 1'b0;
        move_pos   = ~pos;
        @(posedge clk); #1;
        check("no_result_at_n1", {move_ack, move_err}, 0);
        @(posedge clk); #1;
        check("ack", move_ack, exp_ack);
        check("err", move_err, exp_err);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_board", board_word(), 0);
        check("clr_turn", turn, 1);
        check("clr_cnt", move_cnt, 0);
        check("clr_ack_err", {move_ack, move_err}, 0);
        check("clr_ready", move_ready, 1);
        check("clr_game_over", game_over, 0);
    endtask

    task automatic ignored_requests();
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'd0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("gameover_no_result", {move_ack, move_err}, 0);
        end
        move_valid = 1'b0;
        check("gameover_ready", move_ready, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        clear      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_board_async", board_word(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_board", board_word(), 0);
        check("rst_turn", turn, 1);
        check("rst_cnt", move_cnt, 0);
        check("rst_ready", move_ready, 1);
        check("rst_game_over", game_over, 0);
        check("rst_ack_err", {move_ack, move_err}, 0);

        // legal centre move
        do_move(4'd4, 1'b1, 1'b0);
        check("e_board", board_word(), 18'b00_00_00_00_01_00_00_00_00);
        check("e_turn", turn, 2);
        check("e_cnt", move_cnt, 1);

        // occupied cell
        do_move(4'd4, 1'b0, 1'b1);
        check("occ_board", board_word(), 18'b00_00_00_00_01_00_00_00_00);
        check("occ_turn", turn, 2);
        check("occ_cnt", move_cnt, 1);

        // out of range
        do_move(4'b1011, 1'b0, 1'b1);
        check("oor_board", board_word(), 18'b00_00_00_00_01_00_00_00_00);
        check("oor_turn", turn, 2);
        check("oor_cnt", move_cnt, 1);
        @(posedge clk); #1;
        check("err_single_pulse", move_err, 0);

        // highest legal position then lowest illegal one
        do_clear();
        do_move(4'd8, 1'b1, 1'b0);
        check("i_board", board_word(), 18'b00_00_00_00_00_00_00_00_01);
        do_move(4'd9, 1'b0, 1'b1);
        check("pos9_cnt", move_cnt, 1);

        do_clear();

`ifndef BOARD_WIN_DETECT_EN
        // nine legal moves -> draw
        for (int k = 0; k < 9; k++) begin
            do_move(4'(k), 1'b1, 1'b0);
            check("fill_cnt", move_cnt, k + 1);
            check("fill_turn", turn, (k % 2 == 0) ? 2 : 1);
            check("fill_game_over", game_over, (k == 8) ? 1 : 0);
        end
        check("full_board", board_word(), 18'b01_10_01_10_01_10_01_10_01);
        check("full_ready", move_ready, 0);
        ignored_requests();
        check("full_board_kept", board_word(), 18'b01_10_01_10_01_10_01_10_01);
        check("full_cnt_kept", move_cnt, 9);
`else
        // P1: 0,1,2  P2: 3,4 -> P1 completes the top row on move 5
        do_move(4'd0, 1'b1, 1'b0);
        do_move(4'd3, 1'b1, 1'b0);
        do_move(4'd1, 1'b1, 1'b0);
        do_move(4'd4, 1'b1, 1'b0);
        check("pre_win_winner", winner, 0);
        check("pre_win_game_over", game_over, 0);
        do_move(4'd2, 1'b1, 1'b0);
        check("win_winner", winner, 1);
        check("win_game_over", game_over, 1);
        check("win_cnt", move_cnt, 5);
        check("win_board", board_word(), 18'b01_01_01_10_10_00_00_00_00);
        ignored_requests();
        check("win_winner_kept", winner, 1);
`endif

        // clear while in GAME_OVER
        do_clear();
`ifdef BOARD_WIN_DETECT_EN
        check("clr_winner", winner, 0);
`endif

        // clear on the COMMIT edge wins over the write
        do_move(4'd0, 1'b1, 1'b0);
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'd8;
        @(posedge clk); #1;                // accept (N)
        move_valid = 1'b0;
        @(posedge clk); #1;                // CHECK -> COMMIT (N+1)
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;                // COMMIT edge with clear (N+2)
        clear = 1'b0;
        check("cc_ack_err", {move_ack, move_err}, 0);
        check("cc_board", board_word(), 0);
        check("cc_turn", turn, 1);
        check("cc_cnt", move_cnt, 0);
        check("cc_ready", move_ready, 1);
        @(posedge clk); #1;
        check("cc_ack_err_late", {move_ack, move_err}, 0);

        // board is usable again after the discarded move
        do_move(4'd8, 1'b1, 1'b0);
        check("post_cc_board", board_word(), 18'b00_00_00_00_00_00_00_00_01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/board_cell_writer.md
Name: board_cell_writer

Overview:
- Owns the 3x3 game-board register file (cells a..i, 2 bits each) and is the write side of the board interface; the empty-cell checker is the read side.
- Accepts move requests (position 0..8) over a valid/ready handshake and rejects occupied or out-of-range positions.
- Writes the current player's mark, alternates turns and reports board-full / game-over to the game controller.

Parameters:
- CELL_W, 2, width of one cell code.
- NUM_CELLS, 9, number of board cells; positions 0..NUM_CELLS-1 are legal.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- move_valid  in  1  move request present
- move_pos  in  4  requested position, 4'b0000=a .. 4'b1000=i
- move_ready  out  1  block can accept a request this cycle
- move_ack  out  1  one-cycle pulse: move written
- move_err  out  1  one-cycle pulse: move rejected (occupied or pos>8)
- clear  in  1  synchronous board clear / new game
- a,b,c,d,e,f,g,h,i  out  2 each  registered cell contents
- turn  out  2  mark that will be written next (P1 or P2)
- move_cnt  out  4  accepted moves since last clear, 0..9
- game_over  out  1  high while in GAME_OVER

Behaviour:
- Cell codes: 2'b00 EMPTY, 2'b01 P1, 2'b10 P2, 2'b11 unused and never written.
- Reset (rst_n low, asynchronous):
  - all cells EMPTY, turn=P1, move_cnt=0
  - move_ack=0, move_err=0, game_over=0
  - state IDLE
- FSM states:
  - IDLE: move_ready=1. move_valid=1 captures move_pos into pos_q and moves to CHECK.
  - CHECK: move_ready=0. If pos_q>8 or cell[pos_q]!=EMPTY, pulse move_err next cycle and return to IDLE. Otherwise go to COMMIT.
  - COMMIT: cell[pos_q]<=turn, turn toggles P1<->P2, move_cnt+1, move_ack pulses for one cycle. Next state is GAME_OVER if the new move_cnt==9, else IDLE.
  - GAME_OVER: move_ready=0, game_over=1. Requests are ignored; no ack and no err.
- Latency: request accepted at edge N, then ack or err is high during cycle N+2. Only one request is in flight. A new request can be accepted at the edge N+3.
- move_pos is sampled only at the accept edge; later changes have no effect.
- clear=1 in any state:
  - next edge: all cells EMPTY, turn=P1, move_cnt=0, state IDLE
  - any in-flight move is discarded, with no ack or err
  - clear has priority over COMMIT on the same edge
- The err path never changes cells, turn or move_cnt.
- move_cnt saturates at 9. Out-of-range pos (9..15) always gives err, never a write.
- Cell outputs are driven directly from the registers (no combinational path from inputs).

Optional Feature:
- Macro: BOARD_WIN_DETECT_EN.
- Defined:
  - COMMIT evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board.
  - If the mover completes a line, the next state is GAME_OVER regardless of move_cnt.
  - Adds output winner[1:0], reset and clear value EMPTY, set to the mover's code.
  - A win on the 9th move reports winner, not a draw.
- Not defined: no winner port; GAME_OVER is entered only when move_cnt==9.

Decomposition:
- Package board_pkg:
  - typedef cell_t (logic [1:0])
  - constants CELL_EMPTY, CELL_P1, CELL_P2
  - constant NUM_CELLS=9
  - typedef enum writer_state_t {IDLE, CHECK, COMMIT, GAME_OVER}
- Sub-module board_line_check: combinational, 9 cells plus a mark in, returns whether any line is complete. Instantiated only under BOARD_WIN_DETECT_EN.

Test Plan:
- Reset, then read outputs -> all cells 00, turn=01, move_cnt=0, move_ready=1, game_over=0.
- Move pos=4 accepted at edge N -> move_ack high in cycle N+2, e=01, turn=10, move_cnt=1.
- Move pos=4 again -> move_err pulse; e stays 01, turn stays 10, move_cnt stays 1. Move pos=4'b1011 -> move_err, no cell changes.
- Nine legal moves 0..8 -> cells alternate 01/10 starting at a. After the 9th ack: game_over=1, move_ready=0; a further request gives no ack and no err.
- clear asserted in the same cycle as COMMIT, and separately in GAME_OVER -> board all 00, turn=01, move_cnt=0, no ack, state IDLE.
- With BOARD_WIN_DETECT_EN, P1 takes 0,1,2 and P2 takes 3,4 -> after the 5th ack winner=01 and game_over=1 with move_cnt=5.
